// File: rtl/hact_window_ctrl.sv
// Accumulation-window sequencer for the hardtanh/ReLU activation array: clear, accumulate, settle, capture.
// Optional abort input is compiled in when HACT_WINDOW_ABORT_EN is defined.
module hact_window_ctrl #(
  parameter int ODIM = 16,
  parameter int OWID = 8,
  parameter int LWID = OWID + 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef HACT_WINDOW_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 start,
  input  logic [LWID-1:0]      cfg_len,
  output logic                 acc_clr,
  output logic                 acc_en,
  input  logic [OWID*ODIM-1:0] act_data,
  output logic [OWID*ODIM-1:0] o_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic                 busy,
  output logic                 done,
  output logic [LWID-1:0]      win_cnt
);

  localparam logic [LWID-1:0] MAX_LEN = LWID'(2 ** OWID);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_SETTLE,
    S_LATCH,
    S_ABORT
  } state_t;

  state_t               state_q, state_d;
  logic [LWID-1:0]      len_q, len_d;
  logic [LWID-1:0]      win_cnt_q, win_cnt_d;
  logic [OWID*ODIM-1:0] o_data_q, o_data_d;
  logic                 o_valid_q, o_valid_d;
  logic                 done_q, done_d;
  logic                 abort_req;
  logic [LWID-1:0]      start_len;

  // A programmed length of zero selects the longest window the output width allows.
  assign start_len = (cfg_len == '0) ? MAX_LEN : cfg_len;

  always_comb begin
`ifdef HACT_WINDOW_ABORT_EN
    abort_req = abort;
`else
    abort_req = 1'b0;
`endif
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d   = state_q;
    len_d     = len_q;
    win_cnt_d = win_cnt_q;
    o_data_d  = o_data_q;
    o_valid_d = o_valid_q;
    done_d    = 1'b0;

    if (o_valid_q && o_ready) o_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = start_len;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        win_cnt_d = '0;
        state_d   = abort_req ? S_ABORT : S_ACCUM;
      end
      S_ACCUM: begin
        if (win_cnt_q != len_q) win_cnt_d = win_cnt_q + LWID'(1);
        if (abort_req)                state_d = S_ABORT;
        else if (win_cnt_d == len_q)  state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = abort_req ? S_ABORT : S_LATCH;
      end
      S_LATCH: begin
        // A capture that coincides with a consume keeps o_valid set.
        if (!o_valid_q || o_ready) begin
          o_data_d  = act_data;
          o_valid_d = 1'b1;
          done_d    = 1'b1;
          if (start) begin
            len_d   = start_len;
            state_d = S_CLEAR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      win_cnt_q <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      len_q     <= len_d;
      win_cnt_q <= win_cnt_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      done_q    <= done_d;
    end
  end

  assign acc_clr = (state_q == S_CLEAR) || (state_q == S_ABORT);
  assign acc_en  = (state_q == S_ACCUM);
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign win_cnt = win_cnt_q;

endmodule

// File: tb/tb_hact_window_ctrl.sv
// Directed bench for hact_window_ctrl: vector table of single windows plus back-pressure,
// back-to-back, async-reset and (with HACT_WINDOW_ABORT_EN) abort sequences.
module tb_hact_window_ctrl;

  localparam int ODIM = 16;
  localparam int OWID = 8;
  localparam int LWID = OWID + 1;
  localparam int DW   = OWID * ODIM;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            o_ready = 1'b1;
  logic [LWID-1:0] cfg_len = '0;
  logic            acc_clr, acc_en, o_valid, busy, done;
  logic [DW-1:0]   act_data, o_data;
  logic [LWID-1:0] win_cnt;
`ifdef HACT_WINDOW_ABORT_EN
  logic            abort = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int acc;

  hact_window_ctrl #(.ODIM(ODIM), .OWID(OWID), .LWID(LWID)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef HACT_WINDOW_ABORT_EN
    .abort   (abort),
`endif
    .start   (start),
    .cfg_len (cfg_len),
    .acc_clr (acc_clr),
    .acc_en  (acc_en),
    .act_data(act_data),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .busy    (busy),
    .done    (done),
    .win_cnt (win_cnt)
  );

  always #5 clk = ~clk;

  // Activation pattern seen by the controller after n accumulate cycles.
  function automatic logic [DW-1:0] act_of(input int n);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < ODIM; i++) r[i*OWID +: OWID] = OWID'(n + i * 17);
    return r;
  endfunction

  // Stand-in for the upstream accumulators.
  always @(posedge clk or posedge rst) begin
    if (rst)          acc <= 0;
    else if (acc_clr) acc <= 0;
    else if (acc_en)  acc <= acc + 1;
  end
  assign act_data = act_of(acc);

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One window from IDLE; samples are taken #1 after edge t0+e.
  task automatic run_window(input logic [LWID-1:0] cfg, input int exp_len,
                            input int exp_done_edge, input string tag);
    int en_cnt, en_first, en_last, done_edge, done_cnt, clr_cnt;
    logic [DW-1:0]   data_at_done;
    logic            valid_at_done;
    logic [LWID-1:0] wc_at_done;
    en_cnt = 0; en_first = -1; en_last = -1; done_edge = -1; done_cnt = 0; clr_cnt = 0;
    data_at_done = '0; valid_at_done = 1'b0; wc_at_done = '0;
    start = 1'b1; cfg_len = cfg;
    step();
    start = 1'b0; cfg_len = 9'h1AA;
    check({tag, "/clr_t1"}, acc_clr, 1'b1);
    check({tag, "/en_t1"},  acc_en,  1'b0);
    for (int e = 1; e <= 300; e++) begin
      step();
      if (acc_en) begin
        en_cnt++;
        if (en_first < 0) en_first = e;
        en_last = e;
      end
      if (acc_clr) clr_cnt++;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = e; data_at_done = o_data; valid_at_done = o_valid; wc_at_done = win_cnt;
        end
      end
      if (!busy) break;
    end
    check({tag, "/en_cnt"},    en_cnt,    exp_len);
    check({tag, "/en_first"},  en_first,  1);
    check({tag, "/en_last"},   en_last,   exp_len);
    check({tag, "/clr_extra"}, clr_cnt,   0);
    check({tag, "/done_edge"}, done_edge, exp_done_edge);
    check({tag, "/done_cnt"},  done_cnt,  1);
    check({tag, "/valid"},     valid_at_done, 1'b1);
    check({tag, "/data"},      data_at_done,  act_of(exp_len));
    check({tag, "/win_cnt"},   wc_at_done,    exp_len);
    step();
    check({tag, "/done_pulse"}, done, 1'b0);
    check({tag, "/idle"},       busy, 1'b0);
  endtask

  typedef struct {
    logic [LWID-1:0] cfg;
    logic            rdy;
    int              exp_len;
    int              exp_done_edge;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int dones, last, bad_gap, idle_seen, bad_data, bad_clr;
    bit seen_done;

    vecs[0] = '{cfg: 9'd4, rdy: 1'b1, exp_len: 4,   exp_done_edge: 7};
    vecs[1] = '{cfg: 9'd1, rdy: 1'b1, exp_len: 1,   exp_done_edge: 4};
    vecs[2] = '{cfg: 9'd0, rdy: 1'b1, exp_len: 256, exp_done_edge: 259};
    vecs[3] = '{cfg: 9'd9, rdy: 1'b1, exp_len: 9,   exp_done_edge: 12};
    vecs[4] = '{cfg: 9'd2, rdy: 1'b0, exp_len: 2,   exp_done_edge: 5};

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst/acc_clr", acc_clr, 1'b0);
    check("rst/acc_en",  acc_en,  1'b0);
    check("rst/o_valid", o_valid, 1'b0);
    check("rst/o_data",  o_data,  '0);
    check("rst/busy",    busy,    1'b0);
    check("rst/done",    done,    1'b0);
    check("rst/win_cnt", win_cnt, '0);
    step();
    step();
    #2 rst = 1'b0;
    step();
    check("idle/busy", busy, 1'b0);

    // Single-window vectors
    for (int i = 0; i < 5; i++) begin
      o_ready = vecs[i].rdy;
      run_window(vecs[i].cfg, vecs[i].exp_len, vecs[i].exp_done_edge, $sformatf("vec%0d", i));
    end

    // Back-pressure: o_valid held from vec4, second window waits in LATCH
    check("bp/pre_valid", o_valid, 1'b1);
    start = 1'b1; cfg_len = 9'd3;
    step();
    start = 1'b0; cfg_len = '0;
    for (int e = 1; e <= 4; e++) step();
    for (int e = 5; e <= 9; e++) begin
      step();
      check($sformatf("bp/hold_busy_%0d", e),  busy,    1'b1);
      check($sformatf("bp/hold_en_%0d", e),    acc_en,  1'b0);
      check($sformatf("bp/hold_done_%0d", e),  done,    1'b0);
      check($sformatf("bp/hold_valid_%0d", e), o_valid, 1'b1);
      check($sformatf("bp/hold_data_%0d", e),  o_data,  act_of(2));
    end
    check("bp/hold_wc", win_cnt, 3);
    o_ready = 1'b1;
    step();
    check("bp/cap_done",  done,    1'b1);
    check("bp/cap_valid", o_valid, 1'b1);
    check("bp/cap_data",  o_data,  act_of(3));
    check("bp/cap_idle",  busy,    1'b0);
    step();
    check("bp/drain_valid", o_valid, 1'b0);
    check("bp/drain_done",  done,    1'b0);

    // Back-to-back windows with start held high
    dones = 0; last = -1; bad_gap = 0; idle_seen = 0; bad_data = 0; bad_clr = 0;
    start = 1'b1; cfg_len = 9'd2;
    step();
    for (int e = 1; e <= 25; e++) begin
      step();
      if (!busy) idle_seen++;
      if (done) begin
        if (last < 0 && e != 5) bad_gap++;
        if (last >= 0 && e - last != 5) bad_gap++;
        last = e;
        dones++;
        if (o_data !== act_of(2)) bad_data++;
        if (!acc_clr) bad_clr++;
      end
    end
    start = 1'b0;
    check("b2b/dones",     dones,     5);
    check("b2b/gap",       bad_gap,   0);
    check("b2b/no_idle",   idle_seen, 0);
    check("b2b/data",      bad_data,  0);
    check("b2b/reclear",   bad_clr,   0);
    for (int e = 0; e < 30; e++) begin
      step();
      if (!busy) break;
    end
    check("b2b/finish_idle", busy, 1'b0);
    step();

    // Asynchronous reset in the third ACCUM cycle
    start = 1'b1; cfg_len = 9'd8;
    step();
    start = 1'b0; cfg_len = 9'h1AA;
    step(); step(); step();
    check("arst/pre_en", acc_en,  1'b1);
    check("arst/pre_wc", win_cnt, 2);
    #2 rst = 1'b1;
    #1;
    check("arst/acc_clr", acc_clr, 1'b0);
    check("arst/acc_en",  acc_en,  1'b0);
    check("arst/o_valid", o_valid, 1'b0);
    check("arst/o_data",  o_data,  '0);
    check("arst/busy",    busy,    1'b0);
    check("arst/done",    done,    1'b0);
    check("arst/win_cnt", win_cnt, '0);
    @(posedge clk);
    #1;
    check("arst/held", busy, 1'b0);
    #2 rst = 1'b0;
    step();
    o_ready = 1'b1;
    run_window(9'd5, 5, 8, "post_rst");

`ifdef HACT_WINDOW_ABORT_EN
    // Abort in ACCUM keeps the previously captured result
    o_ready = 1'b0;
    run_window(9'd3, 3, 6, "pre_abort");
    seen_done = 1'b0;
    start = 1'b1; cfg_len = 9'd6;
    step();
    start = 1'b0;
    step(); step();
    if (done) seen_done = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    if (done) seen_done = 1'b1;
    check("abort/clr",  acc_clr, 1'b1);
    check("abort/en",   acc_en,  1'b0);
    check("abort/busy", busy,    1'b1);
    step();
    if (done) seen_done = 1'b1;
    check("abort/idle",    busy,      1'b0);
    check("abort/clr_end", acc_clr,   1'b0);
    check("abort/no_done", seen_done, 1'b0);
    check("abort/valid",   o_valid,   1'b1);
    check("abort/data",    o_data,    act_of(3));
    o_ready = 1'b1;
    step();
    check("abort/drain", o_valid, 1'b0);
`else
    seen_done = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
